// File: rtl/sd_crc_engine.sv
// Bit-serial CRC generator/checker: consumes DATA_W-bit words MSB first over valid/ready
// and reports the final remainder plus a compare against an expected CRC.
module sd_crc_engine #(
  parameter int unsigned        CRC_W  = 7,
  parameter logic [CRC_W-1:0]   POLY   = CRC_W'(7'h09),
  parameter logic [CRC_W-1:0]   INIT   = '0,
  parameter int unsigned        DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  input  logic              din_last,
  output logic              din_ready,
  input  logic [CRC_W-1:0]  chk_crc,
  output logic [CRC_W-1:0]  crc_out,
  output logic              crc_valid,
  output logic              crc_match,
  output logic              busy
);

  localparam int unsigned CntW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [1:0] {StIdle, StAccept, StShift, StDone} state_t;

  state_t            state;
  logic [CRC_W-1:0]  rem;
  logic [CRC_W-1:0]  rem_next;
  logic [DATA_W-1:0] sh;
  logic [CntW-1:0]   cnt;
  logic              last;
  logic              fb;

  // One step of the direct (non-augmented) CRC division.
  always_comb begin
    fb       = rem[CRC_W-1] ^ sh[DATA_W-1];
    rem_next = (rem << 1) ^ (fb ? POLY : '0);
  end

  // din_ready and busy are registered decodes of the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= StIdle;
      rem       <= '0;
      sh        <= '0;
      cnt       <= '0;
      last      <= 1'b0;
      crc_out   <= '0;
      crc_valid <= 1'b0;
      crc_match <= 1'b0;
      din_ready <= 1'b0;
      busy      <= 1'b0;
    end else begin
      crc_valid <= 1'b0;
      unique case (state)
        StIdle: begin
          if (start) begin
            rem       <= INIT;
            state     <= StAccept;
            din_ready <= 1'b1;
            busy      <= 1'b1;
          end
        end
        StAccept: begin
          if (start) begin
            rem <= INIT;
          end else if (din_valid) begin
            sh        <= din;
            last      <= din_last;
            cnt       <= CntW'(DATA_W - 1);
            state     <= StShift;
            din_ready <= 1'b0;
          end
        end
        StShift: begin
          if (start) begin
            rem       <= INIT;
            state     <= StAccept;
            din_ready <= 1'b1;
          end else begin
            rem <= rem_next;
            sh  <= sh << 1;
            cnt <= cnt - 1'b1;
            if (cnt == '0) begin
              if (last) begin
                state <= StDone;
              end else begin
                state     <= StAccept;
                din_ready <= 1'b1;
              end
            end
          end
        end
        StDone: begin
          crc_out   <= rem;
          crc_match <= (rem == chk_crc);
          crc_valid <= 1'b1;
          if (start) begin
            rem       <= INIT;
            state     <= StAccept;
            din_ready <= 1'b1;
          end else begin
            state     <= StIdle;
            din_ready <= 1'b0;
            busy      <= 1'b0;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule
